nios_mul_pipe_unit: RTL and testbench

Parametrised, pipelined integer multiply unit for the Nios II custom-datapath path. It is the successor to the fixed 16x16 three-partial-product multiply cell. It forms the full 2*WIDTH product from four HALF-width partial products and supports signed, unsigned and mixed-sign high-word modes. It uses a valid/ready handshake with backpressure, flush and an ID tag, and sits between the E-stage operand mux and the writeback arbiter.

---
 rtl/nios_mul_pkg.sv | 13 +
 rtl/nios_mul_pipe_unit_if.sv | 30 +++
 rtl/nios_mul_pp_stage.sv | 37 +++
 rtl/nios_mul_pipe_unit.sv | 105 ++++++++++
 tb/tb_nios_mul_pipe_unit.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nios_mul_pkg.sv
// Shared definitions for the pipelined multiply unit: op-code encoding.
package nios_mul_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_MUL    = 2'd0,   // low word of product
        OP_MULXUU = 2'd1,   // high word, both unsigned
        OP_MULXSU = 2'd2,   // high word, src1 signed, src2 unsigned
        OP_MULXSS = 2'd3    // high word, both signed
    } mul_op_e;

endpackage

// File: rtl/nios_mul_pipe_unit_if.sv
// Operand/result handshake bundle between the E-stage mux, the multiply
// unit and the writeback arbiter.
interface nios_mul_pipe_unit_if
    import nios_mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_op;
    logic [WIDTH-1:0] in_src1;
    logic [WIDTH-1:0] in_src2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );

endinterface

// File: rtl/nios_mul_pp_stage.sv
// Four half-width partial products plus the signed-mode correction term.
// The products are plain unsigned multiplies so they map onto DSP blocks.
module nios_mul_pp_stage
    import nios_mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  mul_op_e          op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic [WIDTH-1:0] pp_ll,
    output logic [WIDTH-1:0] pp_lh,
    output logic [WIDTH-1:0] pp_hl,
    output logic [WIDTH-1:0] pp_hh,
    output logic [WIDTH-1:0] corr
);
    localparam int HALF = WIDTH / 2;

    logic [WIDTH-1:0] a_lo, a_hi, b_lo, b_hi;
    logic             sub_b, sub_a;

    assign a_lo = {{HALF{1'b0}}, src1[HALF-1:0]};
    assign a_hi = {{HALF{1'b0}}, src1[WIDTH-1:HALF]};
    assign b_lo = {{HALF{1'b0}}, src2[HALF-1:0]};
    assign b_hi = {{HALF{1'b0}}, src2[WIDTH-1:HALF]};

    assign pp_ll = a_lo * b_lo;
    assign pp_lh = a_lo * b_hi;
    assign pp_hl = a_hi * b_lo;
    assign pp_hh = a_hi * b_hi;

    // A negative signed operand contributes -(other operand) << WIDTH.
    assign sub_b = ((op == OP_MULXSU) || (op == OP_MULXSS)) && src1[WIDTH-1];
    assign sub_a = (op == OP_MULXSS) && src2[WIDTH-1];
    assign corr  = (sub_b ? src2 : '0) + (sub_a ? src1 : '0);

endmodule

// File: rtl/nios_mul_pipe_unit.sv
// Two-stage pipelined multiplier: S1 holds partial products, S2 holds the
// selected product word and is the output register.
module nios_mul_pipe_unit
    import nios_mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    output logic               busy,
    nios_mul_pipe_unit_if.slave bus
);
    localparam int HALF = WIDTH / 2;

    logic               s1_valid;
    logic [WIDTH-1:0]   s1_pp_ll, s1_pp_lh, s1_pp_hl, s1_pp_hh, s1_corr;
    mul_op_e            s1_op;
    logic [TAG_W-1:0]   s1_tag;
    logic               s2_valid;
    logic [WIDTH-1:0]   s2_result;
    logic [TAG_W-1:0]   s2_tag;

    logic [WIDTH-1:0]   pp_ll, pp_lh, pp_hl, pp_hh, corr;
    logic               s1_adv, accept;
    logic [WIDTH:0]     mid;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   sel;

    nios_mul_pp_stage #(.WIDTH(WIDTH)) u_pp (
        .op    (mul_op_e'(bus.in_op)),
        .src1  (bus.in_src1),
        .src2  (bus.in_src2),
        .pp_ll (pp_ll),
        .pp_lh (pp_lh),
        .pp_hl (pp_hl),
        .pp_hh (pp_hh),
        .corr  (corr)
    );

    assign s1_adv       = !s2_valid || bus.out_ready;
    assign bus.in_ready = reset_n && !flush && (!s1_valid || s1_adv);
    assign accept       = bus.in_valid && bus.in_ready;

    // Combine partial products; the middle sum keeps its carry bit.
    always_comb begin
        mid  = {1'b0, s1_pp_lh} + {1'b0, s1_pp_hl};
        prod = {{WIDTH{1'b0}}, s1_pp_ll}
             + {{(HALF-1){1'b0}}, mid, {HALF{1'b0}}}
             + {s1_pp_hh, {WIDTH{1'b0}}}
             - {s1_corr, {WIDTH{1'b0}}};
        sel  = (s1_op == OP_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end

    // S1: capture products on accept only, so DSP registers keep their enable.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_pp_ll <= '0;
            s1_pp_lh <= '0;
            s1_pp_hl <= '0;
            s1_pp_hh <= '0;
            s1_corr  <= '0;
            s1_op    <= OP_MUL;
            s1_tag   <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_pp_ll <= pp_ll;
            s1_pp_lh <= pp_lh;
            s1_pp_hl <= pp_hl;
            s1_pp_hh <= pp_hh;
            s1_corr  <= corr;
            s1_op    <= mul_op_e'(bus.in_op);
            s1_tag   <= bus.in_tag;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // S2: output register, holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_tag    <= '0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= sel;
                s2_tag    <= s1_tag;
            end
        end
    end

    assign bus.out_valid  = s2_valid;
    assign bus.out_result = s2_result;
    assign bus.out_tag    = s2_tag;
    assign busy           = s1_valid || s2_valid;

endmodule

// File: tb/tb_nios_mul_pipe_unit.sv
// Self-checking bench: a 32-bit unit for directed/handshake scenarios and an
// 8-bit unit for a randomized operand sweep, both against a reference model.
module tb_nios_mul_pipe_unit;
    import nios_mul_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, flush, flush8, busy, busy8;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t q[$];
    exp_t q8[$];

    nios_mul_pipe_unit_if #(.WIDTH(32), .TAG_W(5)) bus ();
    nios_mul_pipe_unit_if #(.WIDTH(8),  .TAG_W(5)) bus8 ();

    nios_mul_pipe_unit #(.WIDTH(32), .TAG_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .busy(busy), .bus(bus)
    );

    nios_mul_pipe_unit #(.WIDTH(8), .TAG_W(5)) dut8 (
        .clk(clk), .reset_n(reset_n), .flush(flush8), .busy(busy8), .bus(bus8)
    );

    // Reference: sign-extend per op, multiply at 64 bits, pick the word.
    function automatic logic [31:0] ref_mul(input int w, input logic [1:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
        longint unsigned mask, ea, eb, p;
        mask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        ea = {32'd0, a} & mask;
        eb = {32'd0, b} & mask;
        if ((op == 2'd2 || op == 2'd3) && a[w-1]) ea = ea | ~mask;
        if (op == 2'd3 && b[w-1]) eb = eb | ~mask;
        p = ea * eb;
        if (op == 2'd0) return 32'(p & mask);
        return 32'((p >> w) & mask);
    endfunction

    task automatic step(input logic v, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag, input logic ordy,
                        input logic fl, output logic acc, output logic took,
                        output logic [31:0] res, output logic [4:0] tg, output logic ov);
        bus.in_valid  = v;
        bus.in_op     = op;
        bus.in_src1   = a;
        bus.in_src2   = b;
        bus.in_tag    = tag;
        bus.out_ready = ordy;
        flush         = fl;
        #1;
        acc  = v & bus.in_ready;
        ov   = bus.out_valid;
        took = ov & ordy;
        res  = bus.out_result;
        tg   = bus.out_tag;
        if (acc) q.push_back('{ref_mul(32, op, a, b), tag});
        @(posedge clk);
        #1;
    endtask

    task automatic step8(input logic v, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [4:0] tag, input logic ordy,
                         output logic took, output logic [7:0] res, output logic [4:0] tg);
        logic acc;
        bus8.in_valid  = v;
        bus8.in_op     = op;
        bus8.in_src1   = a;
        bus8.in_src2   = b;
        bus8.in_tag    = tag;
        bus8.out_ready = ordy;
        #1;
        acc  = v & bus8.in_ready;
        took = bus8.out_valid & ordy;
        res  = bus8.out_result;
        tg   = bus8.out_tag;
        if (acc) q8.push_back('{ref_mul(8, op, {24'd0, a}, {24'd0, b}), tag});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b0)
            $display("FAIL reset_ctl: out_valid=%b busy=%b in_ready=%b, want 0 0 0",
                     bus.out_valid, busy, bus.in_ready);
        else n_pass++;
        n_checks++;
        if (bus.out_result !== 32'd0 || bus.out_tag !== 5'd0)
            $display("FAIL reset_data: result=%h tag=%0d, want 0 0", bus.out_result, bus.out_tag);
        else n_pass++;
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_latency();
        logic acc, took, ov;
        logic [31:0] res;
        logic [4:0] tg;
        step(1, 2'd0, 32'h0001_0000, 32'h0001_0000, 5'd3, 1, 0, acc, took, res, tg, ov);
        n_checks++;
        if (acc !== 1'b1) $display("FAIL lat_acc0: acc=%b want 1", acc); else n_pass++;
        step(1, 2'd1, 32'h0001_0000, 32'h0001_0000, 5'd4, 1, 0, acc, took, res, tg, ov);
        n_checks++;
        if (acc !== 1'b1 || ov !== 1'b0)
            $display("FAIL lat_cyc1: acc=%b ov=%b want 1 0", acc, ov);
        else n_pass++;
        step(0, 2'd0, 0, 0, 0, 1, 0, acc, took, res, tg, ov);
        n_checks++;
        if (ov !== 1'b1 || res !== 32'h0 || tg !== 5'd3)
            $display("FAIL lat_mul: ov=%b res=%h tag=%0d want 1 00000000 3", ov, res, tg);
        else n_pass++;
        step(0, 2'd0, 0, 0, 0, 1, 0, acc, took, res, tg, ov);
        n_checks++;
        if (ov !== 1'b1 || res !== 32'h1 || tg !== 5'd4)
            $display("FAIL lat_mulxuu: ov=%b res=%h tag=%0d want 1 00000001 4", ov, res, tg);
        else n_pass++;
        step(0, 2'd0, 0, 0, 0, 1, 0, acc, took, res, tg, ov);
        n_checks++;
        if (ov !== 1'b0) $display("FAIL lat_empty: ov=%b want 0", ov); else n_pass++;
        q.delete();
    endtask

    task automatic test_all_ones();
        logic acc, took, ov;
        logic [31:0] res;
        logic [4:0] tg;
        logic [1:0] ops [4];
        logic [31:0] want [4];
        int got;
        ops[0] = 2'd1; want[0] = 32'hFFFF_FFFE;
        ops[1] = 2'd2; want[1] = 32'hFFFF_FFFF;
        ops[2] = 2'd3; want[2] = 32'h0000_0000;
        ops[3] = 2'd0; want[3] = 32'h0000_0001;
        got = 0;
        for (int i = 0; i < 12 && got < 4; i++) begin
            if (i < 4)
                step(1, ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'(i + 8), 1, 0,
                     acc, took, res, tg, ov);
            else
                step(0, 2'd0, 0, 0, 0, 1, 0, acc, took, res, tg, ov);
            if (took) begin
                n_checks++;
                if (res !== want[got] || tg !== 5'(got + 8))
                    $display("FAIL ones_op%0d: res=%h tag=%0d want %h %0d",
                             ops[got], res, tg, want[got], got + 8);
                else n_pass++;
                got++;
            end
        end
        n_checks++;
        if (got != 4) $display("FAIL ones_count: got=%0d want 4", got); else n_pass++;
        q.delete();
    endtask

    task automatic test_backpressure();
        logic acc, took, ov, have;
        logic [31:0] res, held, a [3], b [3];
        logic [4:0] tg, held_tag;
        logic [1:0] op [3];
        exp_t e;
        int k;
        for (int i = 0; i < 3; i++) begin
            a[i] = $urandom; b[i] = $urandom; op[i] = 2'($urandom_range(0, 3));
        end
        k = 0; have = 0; held = '0; held_tag = '0;
        for (int c = 0; c < 6; c++) begin
            step(1, op[k], a[k], b[k], 5'(10 + k), 0, 0, acc, took, res, tg, ov);
            if (acc) k++;
            if (ov) begin
                if (!have) begin
                    have = 1; held = res; held_tag = tg;
                end else begin
                    n_checks++;
                    if (res !== held || tg !== held_tag)
                        $display("FAIL bp_hold: res=%h tag=%0d want %h %0d", res, tg, held, held_tag);
                    else n_pass++;
                end
            end
        end
        n_checks++;
        if (k != 2 || bus.in_ready !== 1'b0)
            $display("FAIL bp_accepts: accepts=%0d in_ready=%b want 2 0", k, bus.in_ready);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            if (k < 3) step(1, op[k], a[k], b[k], 5'(10 + k), 1, 0, acc, took, res, tg, ov);
            else       step(0, 2'd0, 0, 0, 0, 1, 0, acc, took, res, tg, ov);
            if (acc) k++;
            n_checks++;
            if (!took || q.size() == 0) begin
                $display("FAIL bp_drain%0d: took=%b queued=%0d want 1 and an entry", c, took, q.size());
            end else begin
                e = q.pop_front();
                if (res !== e.res || tg !== e.tag)
                    $display("FAIL bp_drain%0d: res=%h tag=%0d want %h %0d", c, res, tg, e.res, e.tag);
                else n_pass++;
            end
        end
        n_checks++;
        if (q.size() != 0 || bus.out_valid !== 1'b0)
            $display("FAIL bp_dup: queued=%0d out_valid=%b want 0 0", q.size(), bus.out_valid);
        else n_pass++;
        q.delete();
    endtask

    task automatic test_flush();
        logic acc, took, ov;
        logic [31:0] res, a, b;
        logic [4:0] tg;
        int got;
        step(1, 2'd1, 32'd5, 32'd7, 5'd1, 0, 0, acc, took, res, tg, ov);
        step(1, 2'd2, 32'd9, 32'd9, 5'd2, 0, 0, acc, took, res, tg, ov);
        step(1, 2'd0, 32'd3, 32'd3, 5'd3, 0, 1, acc, took, res, tg, ov);
        n_checks++;
        if (acc !== 1'b0) $display("FAIL flush_accept: acc=%b want 0", acc); else n_pass++;
        n_checks++;
        if (busy !== 1'b0 || bus.out_valid !== 1'b0)
            $display("FAIL flush_clear: busy=%b out_valid=%b want 0 0", busy, bus.out_valid);
        else n_pass++;
        q.delete();
        a = 32'hFFFF_FFF0; b = 32'h0000_1234;
        got = 0;
        for (int i = 0; i < 8 && got == 0; i++) begin
            if (i == 0) step(1, 2'd2, a, b, 5'd21, 1, 0, acc, took, res, tg, ov);
            else        step(0, 2'd0, 0, 0, 0, 1, 0, acc, took, res, tg, ov);
            if (took) begin
                got = 1;
                n_checks++;
                if (res !== 32'hFFFF_FFFF || tg !== 5'd21)
                    $display("FAIL flush_next: res=%h tag=%0d want ffffffff 21", res, tg);
                else n_pass++;
            end
        end
        n_checks++;
        if (got == 0) $display("FAIL flush_timeout: no result, want one"); else n_pass++;
        q.delete();
    endtask

    task automatic test_reset_mid();
        logic acc, took, ov;
        logic [31:0] res;
        logic [4:0] tg;
        int seen;
        step(1, 2'd3, 32'h8000_0001, 32'h7, 5'd17, 1, 0, acc, took, res, tg, ov);
        n_checks++;
        if (acc !== 1'b1) $display("FAIL rst_mid_acc: acc=%b want 1", acc); else n_pass++;
        reset_n = 1'b0;
        step(0, 2'd0, 0, 0, 0, 1, 0, acc, took, res, tg, ov);
        n_checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b0 ||
            bus.out_result !== 32'd0 || bus.out_tag !== 5'd0)
            $display("FAIL rst_mid_out: ov=%b busy=%b rdy=%b res=%h tag=%0d want all 0",
                     bus.out_valid, busy, bus.in_ready, bus.out_result, bus.out_tag);
        else n_pass++;
        reset_n = 1'b1;
        q.delete();
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 2'd0, 0, 0, 0, 1, 0, acc, took, res, tg, ov);
            if (ov) seen++;
        end
        n_checks++;
        if (seen != 0) $display("FAIL rst_mid_ghost: out_valid cycles=%0d want 0", seen); else n_pass++;
    endtask

    task automatic test_random32();
        logic acc, took, ov;
        logic [31:0] res;
        logic [4:0] tg;
        exp_t e;
        int errs, n;
        errs = 0; n = 0;
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom, $urandom,
                 5'($urandom), 1'($urandom_range(0, 2) != 0), 0, acc, took, res, tg, ov);
            if (took) begin
                n_checks++; n++;
                if (q.size() == 0) begin
                    $display("FAIL rand32_extra: res=%h with nothing outstanding", res);
                end else begin
                    e = q.pop_front();
                    if (res !== e.res || tg !== e.tag) begin
                        errs++;
                        if (errs < 10)
                            $display("FAIL rand32: res=%h tag=%0d want %h %0d", res, tg, e.res, e.tag);
                    end else n_pass++;
                end
            end
        end
        for (int i = 0; i < 10 && q.size() != 0; i++) begin
            step(0, 2'd0, 0, 0, 0, 1, 0, acc, took, res, tg, ov);
            if (took) begin
                n_checks++;
                e = q.pop_front();
                if (res !== e.res || tg !== e.tag)
                    $display("FAIL rand32_drain: res=%h tag=%0d want %h %0d", res, tg, e.res, e.tag);
                else n_pass++;
            end
        end
        n_checks++;
        if (q.size() != 0 || n < 100)
            $display("FAIL rand32_flow: left=%0d results=%0d want 0 and >=100", q.size(), n);
        else n_pass++;
    endtask

    task automatic test_sweep8();
        logic took;
        logic [7:0] res, a, b, corner [5];
        logic [4:0] tg;
        exp_t e;
        int errs, n;
        corner[0] = 8'h00; corner[1] = 8'h01; corner[2] = 8'h7F;
        corner[3] = 8'h80; corner[4] = 8'hFF;
        errs = 0; n = 0;
        for (int i = 0; i < 4000 || q8.size() != 0; i++) begin
            if (i > 4100) break;
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 8'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 8'($urandom);
            step8(1'(i < 4000), 2'($urandom_range(0, 3)), a, b, 5'($urandom),
                  1'(i >= 4000 || $urandom_range(0, 4) != 0), took, res, tg);
            if (took) begin
                n++;
                if (q8.size() == 0) begin
                    errs++;
                end else begin
                    e = q8.pop_front();
                    if (res !== e.res[7:0] || tg !== e.tag) begin
                        errs++;
                        if (errs < 10)
                            $display("FAIL sweep8: res=%h tag=%0d want %h %0d", res, tg, e.res[7:0], e.tag);
                    end
                end
            end
        end
        n_checks++;
        if (errs != 0 || q8.size() != 0 || n < 2000)
            $display("FAIL sweep8_total: errors=%0d left=%0d results=%0d want 0 0 >=2000",
                     errs, q8.size(), n);
        else n_pass++;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; flush8 = 1'b0;
        bus.in_valid = 0; bus.in_op = '0; bus.in_src1 = '0; bus.in_src2 = '0;
        bus.in_tag = '0; bus.out_ready = 0;
        bus8.in_valid = 0; bus8.in_op = '0; bus8.in_src1 = '0; bus8.in_src2 = '0;
        bus8.in_tag = '0; bus8.out_ready = 0;
        test_reset();
        test_latency();
        test_all_ones();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random32();
        test_sweep8();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
